// File: rtl/mips_mem_arbiter_pkg.sv
// Shared definitions for the IF/DM unified-memory arbiter: state and owner
// encodings, default bus widths and the arbitration decision.
package mips_mem_arb_pkg;

  localparam int DEF_ADDR_W       = 32;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_STARVE_LIMIT = 4;
  localparam int STARVE_CNT_W     = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_e;

  // DM wins whenever it asks, unless the starvation guard forces IF through.
  function automatic arb_owner_e pick_winner(input logic dm_req, input logic force_if);
    return (dm_req && !force_if) ? OWN_DM : OWN_IF;
  endfunction

endpackage

// File: rtl/mips_mem_arbiter_if.sv
// Bundle of the IF requester, DM requester and memory-side signals.
// slave  : seen from the arbiter.
// master : seen from the core and memory model driving the arbiter.
interface mips_mem_arbiter_if
  import mips_mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  logic              busy;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready,
    output busy
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready,
    input  busy
  );

endinterface

// File: rtl/mips_mem_arbiter_starve_ctr.sv
// IF starvation counter: counts DM grants won while IF was also waiting,
// clears when IF is granted, saturates at 15 and raises force_if_o once the
// count reaches STARVE_LIMIT with both requesters asking.
module mips_arb_starve_ctr
  import mips_mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clock,
  input  logic reset,
  input  logic grant_if_i,
  input  logic grant_dm_i,
  input  logic if_req_i,
  input  logic dm_req_i,
  output logic force_if_o
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT   = STARVE_LIMIT[STARVE_CNT_W-1:0];
  localparam logic [STARVE_CNT_W-1:0] CNT_MAX = {STARVE_CNT_W{1'b1}};

  logic [STARVE_CNT_W-1:0] cnt_q;
  logic [STARVE_CNT_W-1:0] cnt_d;

  // Next count: IF grant clears, DM grant over a waiting IF counts up to saturation.
  always_comb begin
    cnt_d = cnt_q;
    if (grant_if_i) begin
      cnt_d = '0;
    end else if (grant_dm_i && if_req_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_if_o = (cnt_q == LIMIT) && if_req_i && dm_req_i;

endmodule

// File: rtl/mips_mem_arbiter.sv
// Arbiter sharing one single-ported memory between the instruction-fetch
// port (IF) and the load/store port (DM). DM has fixed priority; one access
// is in flight at a time and the memory command is held until mem_ready.
// Optional IF starvation guard: define MIPS_MEM_ARB_STARVE_GUARD_EN.
module mips_mem_arbiter
  import mips_mem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              clock,
  input  logic              reset,
  mips_mem_arbiter_if.slave bus
);

  if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : g_bad_limit
    $error("STARVE_LIMIT must lie in 1..15");
  end

  arb_state_e        state_q,     state_d;
  arb_owner_e        owner_q,     owner_d;
  logic              if_gnt_q,    if_gnt_d;
  logic              dm_gnt_q,    dm_gnt_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              dm_rvalid_q, dm_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q,  dm_rdata_d;
  logic              mem_en_q,    mem_en_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              busy_q,      busy_d;

  logic       any_req;
  logic       force_if;
  arb_owner_e winner;

  assign any_req = bus.if_req || bus.dm_req;
  assign winner  = pick_winner(bus.dm_req, force_if);

`ifdef MIPS_MEM_ARB_STARVE_GUARD_EN
  logic grant_if;
  logic grant_dm;

  assign grant_if = (state_q == IDLE) && any_req && (winner == OWN_IF);
  assign grant_dm = (state_q == IDLE) && any_req && (winner == OWN_DM);

  mips_arb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clock      (clock),
    .reset      (reset),
    .grant_if_i (grant_if),
    .grant_dm_i (grant_dm),
    .if_req_i   (bus.if_req),
    .dm_req_i   (bus.dm_req),
    .force_if_o (force_if)
  );
`else
  assign force_if = 1'b0;
`endif

  // Next-state and registered-output logic: arbitrate in IDLE, wait for mem_ready in ACCESS.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    if_gnt_d    = 1'b0;
    dm_gnt_d    = 1'b0;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    busy_d      = busy_q;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d  = ACCESS;
          owner_d  = winner;
          mem_en_d = 1'b1;
          busy_d   = 1'b1;
          if (winner == OWN_DM) begin
            dm_gnt_d    = 1'b1;
            mem_we_d    = bus.dm_we;
            mem_addr_d  = bus.dm_addr;
            mem_wdata_d = bus.dm_wdata;
          end else begin
            if_gnt_d    = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = bus.if_addr;
            mem_wdata_d = '0;
          end
        end
      end
      ACCESS: begin
        if (bus.mem_ready) begin
          if (owner_q == OWN_DM) begin
            dm_rvalid_d = 1'b1;
            // A store completion returns zero rather than whatever the bus carries.
            dm_rdata_d  = mem_we_q ? '0 : bus.mem_rdata;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = bus.mem_rdata;
          end
          state_d  = IDLE;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          busy_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      if_gnt_q    <= 1'b0;
      dm_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      if_gnt_q    <= if_gnt_d;
      dm_gnt_q    <= dm_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      dm_rvalid_q <= dm_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.if_gnt    = if_gnt_q;
  assign bus.dm_gnt    = dm_gnt_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.dm_rvalid = dm_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = busy_q;

endmodule
